twiddle_rotator64: RTL and testbench

//  Reads the 64-entry twiddle ROM and rotates each sample by its coefficient.
//  - Holds the 6-bit frame index counter and drives the ROM ADDR port.
//  - Takes the WR/WI coefficients back from the ROM.
//  - Multiplies each incoming complex sample by WR + jWI.
//  - Sits between the first 8-point stage and the second 8-point stage of the
//    64-point FFT/IFFT pipeline. Frames arrive in 8x8 (row-major) index order.

---
 rtl/twiddle_rotator64_pkg.sv | 14 +
 rtl/twiddle_rotator64_cmul_pipe.sv | 67 ++++++
 rtl/twiddle_rotator64.sv | 90 +++++++++
 tb/tb_twiddle_rotator64.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/twiddle_rotator64_pkg.sv
// Shared types and defaults for the 64-point twiddle rotator.
// Holds the FSM state type, index width and nb/nw defaults.
package twiddle_rotator64_pkg;

    localparam int NB_DEF = 16;
    localparam int NW_DEF = 16;
    localparam int IDX_W  = 6;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

endpackage

// File: rtl/twiddle_rotator64_cmul_pipe.sv
// Two-stage complex multiplier: S2 products, S3 add/sub and bit select.
// Ports: clk, rst_n (async low), en (advance), dr/di sample,
//        wr/wi Q1.(nw-1) coefficient, dor/doi nb+1-bit result.
// Build option: TWIDDLE_ROUND_EN adds round-half-up before the select.
module twiddle_rotator64_cmul_pipe #(
    parameter int nb = 16,
    parameter int nw = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic signed [nb-1:0] dr,
    input  logic signed [nb-1:0] di,
    input  logic signed [nw-1:0] wr,
    input  logic signed [nw-1:0] wi,
    output logic signed [nb:0]   dor,
    output logic signed [nb:0]   doi
);

    localparam int PW = nb + nw;

    logic signed [PW-1:0] p_rr;
    logic signed [PW-1:0] p_ii;
    logic signed [PW-1:0] p_ri;
    logic signed [PW-1:0] p_ir;
    logic signed [PW:0]   re;
    logic signed [PW:0]   im;
    logic                 unused_bits;

`ifdef TWIDDLE_ROUND_EN
    // Half an output LSB: the output LSB sits at bit nw-1.
    localparam logic [PW:0] HALF =
        {{(PW-nw+2){1'b0}}, 1'b1, {(nw-2){1'b0}}};

    always_comb begin
        re = {p_rr[PW-1], p_rr} - {p_ii[PW-1], p_ii} + HALF;
        im = {p_ri[PW-1], p_ri} + {p_ir[PW-1], p_ir} + HALF;
    end
`else
    always_comb begin
        re = {p_rr[PW-1], p_rr} - {p_ii[PW-1], p_ii};
        im = {p_ri[PW-1], p_ri} + {p_ir[PW-1], p_ir};
    end
`endif

    // Top bit cannot carry information (|result| <= sqrt2 * 2^(nb-1)).
    assign unused_bits = ^{re[PW], im[PW], re[nw-2:0], im[nw-2:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_rr <= '0;
            p_ii <= '0;
            p_ri <= '0;
            p_ir <= '0;
            dor  <= '0;
            doi  <= '0;
        end else if (en) begin
            p_rr <= PW'(dr) * PW'(wr);
            p_ii <= PW'(di) * PW'(wi);
            p_ri <= PW'(dr) * PW'(wi);
            p_ir <= PW'(di) * PW'(wr);
            dor  <= re[PW-1:nw-1];
            doi  <= im[PW-1:nw-1];
        end
    end

endmodule

// File: rtl/twiddle_rotator64.sv
// Twiddle rotator between the two 8-point stages of the 64-point FFT.
// Ports: CLK, RST (async low), ED enable, START frame mark, DR/DI sample,
//        ADDR ROM index, WR/WI ROM coefficient, DOR/DOI result, RDY.
// Build option: TWIDDLE_ROUND_EN selects rounding in the multiplier.
module twiddle_rotator64
    import twiddle_rotator64_pkg::*;
#(
    parameter int nb = NB_DEF,
    parameter int nw = NW_DEF
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 ED,
    input  logic                 START,
    input  logic signed [nb-1:0] DR,
    input  logic signed [nb-1:0] DI,
    output logic [IDX_W-1:0]     ADDR,
    input  logic signed [nw-1:0] WR,
    input  logic signed [nw-1:0] WI,
    output logic signed [nb:0]   DOR,
    output logic signed [nb:0]   DOI,
    output logic                 RDY
);

    state_t               state;
    logic                 run;
    logic [IDX_W-1:0]     cnt;
    logic signed [nb-1:0] dr1;
    logic signed [nb-1:0] di1;
    logic signed [nw-1:0] wr1;
    logic signed [nw-1:0] wi1;
    logic                 m1;
    logic                 m2;

    assign run  = (state == RUN);
    assign ADDR = (START || !run) ? '0 : cnt;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (ED) begin
            if (START) begin
                state <= RUN;
                cnt   <= IDX_W'(1);
            end else if (run) begin
                cnt <= cnt + IDX_W'(1);
            end
        end
    end

    // S1 capture plus the index-0 marker chain; RDY is a one-cycle pulse.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            dr1 <= '0;
            di1 <= '0;
            wr1 <= '0;
            wi1 <= '0;
            m1  <= 1'b0;
            m2  <= 1'b0;
            RDY <= 1'b0;
        end else begin
            RDY <= ED & m2;
            if (ED) begin
                dr1 <= DR;
                di1 <= DI;
                wr1 <= WR;
                wi1 <= WI;
                m1  <= (ADDR == '0) & (START | run);
                m2  <= m1;
            end
        end
    end

    twiddle_rotator64_cmul_pipe #(
        .nb(nb),
        .nw(nw)
    ) u_cmul (
        .clk  (CLK),
        .rst_n(RST),
        .en   (ED),
        .dr   (dr1),
        .di   (di1),
        .wr   (wr1),
        .wi   (wi1),
        .dor  (DOR),
        .doi  (DOI)
    );

endmodule

// File: tb/tb_twiddle_rotator64.sv
// Scoreboard bench for twiddle_rotator64 with a behavioural twiddle ROM.
// Honours TWIDDLE_ROUND_EN for the hand-computed expectations.
`timescale 1ns/1ps
module tb_twiddle_rotator64;

    localparam int NB = 16;
    localparam int NW = 16;

`ifdef TWIDDLE_ROUND_EN
    localparam int H0   = 1000;
    localparam int H20I = -707;
`else
    localparam int H0   = 999;
    localparam int H20I = -708;
`endif

    logic                 CLK = 1'b0;
    logic                 RST = 1'b1;
    logic                 ED = 1'b0;
    logic                 START = 1'b0;
    logic signed [NB-1:0] DR = '0;
    logic signed [NB-1:0] DI = '0;
    logic [5:0]           ADDR;
    logic signed [NW-1:0] WR;
    logic signed [NW-1:0] WI;
    logic signed [NB:0]   DOR;
    logic signed [NB:0]   DOI;
    logic                 RDY;

    logic signed [NW-1:0] wr_rom [64];
    logic signed [NW-1:0] wi_rom [64];

    assign WR = wr_rom[ADDR];
    assign WI = wi_rom[ADDR];

    always #5 CLK = ~CLK;

    twiddle_rotator64 #(.nb(NB), .nw(NW)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .ED   (ED),
        .START(START),
        .DR   (DR),
        .DI   (DI),
        .ADDR (ADDR),
        .WR   (WR),
        .WI   (WI),
        .DOR  (DOR),
        .DOI  (DOI),
        .RDY  (RDY)
    );

    typedef struct {
        int due;
        int idx;
        int dor;
        int doi;
        bit rdy;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ed_issue = 0;
    int   ed_seen = 0;
    bit   run_m = 0;
    int   cnt_m = 0;
    bit   have_last = 0;
    int   last_dor = 0;
    int   last_doi = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int rnd(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(-x + 0.5);
    endfunction

    // a*c - b*d scaled by 2^-(NW-1), floor or round-half-up
    function automatic int mdl(input int a, input int b, input int c, input int d);
        longint p;
        p = longint'(a) * longint'(c) - longint'(b) * longint'(d);
`ifdef TWIDDLE_ROUND_EN
        p = p + (longint'(1) <<< (NW - 2));
`endif
        p = p >>> (NW - 1);
        return int'(p);
    endfunction

    task automatic step(input bit ed, input bit st, input int dr, input int di,
                        input bit hand = 0, input int hr = 0, input int hi = 0);
        int   a;
        exp_t e;
        @(negedge CLK);
        ED    = ed;
        START = st;
        DR    = NB'(dr);
        DI    = NB'(di);
        #1;
        a = (st || !run_m) ? 0 : cnt_m;
        if (RST) chk("addr", longint'(ADDR), longint'(a));
        if (ed) begin
            ed_issue++;
            if (RST) begin
                e.due = ed_issue + 2;
                e.idx = a;
                e.dor = hand ? hr :
                    mdl(dr, di, int'(wr_rom[a]), int'(wi_rom[a]));
                e.doi = hand ? hi :
                    mdl(dr, -di, int'(wi_rom[a]), int'(wr_rom[a]));
                e.rdy = (a == 0) && (st || run_m);
                q.push_back(e);
                if (st) begin
                    run_m = 1;
                    cnt_m = 1;
                end else if (run_m) begin
                    cnt_m = (cnt_m + 1) % 64;
                end
            end
        end
    endtask

    task automatic do_reset(input bit ed);
        @(negedge CLK);
        ED    = ed;
        START = 1'b0;
        RST   = 1'b0;
        if (ed) ed_issue++;
        #1;
        q.delete();
        have_last = 0;
        run_m = 0;
        cnt_m = 0;
        chk("rst_addr", longint'(ADDR), 0);
        chk("rst_dor", longint'(DOR), 0);
        chk("rst_doi", longint'(DOI), 0);
        chk("rst_rdy", longint'(RDY), 0);
    endtask

    task automatic release_rst();
        @(negedge CLK);
        ED  = 1'b0;
        RST = 1'b1;
    endtask

    // Monitor: output for the sample taken at ED edge n appears after edge n+2.
    initial begin
        bit   s_ed;
        exp_t e;
        forever begin
            @(posedge CLK);
            s_ed = ED;
            #1;
            if (s_ed) begin
                ed_seen++;
                if (RST && q.size() > 0 && q[0].due == ed_seen) begin
                    e = q.pop_front();
                    chk($sformatf("dor[%0d]", e.idx), longint'(DOR), longint'(e.dor));
                    chk($sformatf("doi[%0d]", e.idx), longint'(DOI), longint'(e.doi));
                    chk($sformatf("rdy[%0d]", e.idx), longint'(RDY), longint'(e.rdy));
                    last_dor = e.dor;
                    last_doi = e.doi;
                    have_last = 1;
                end
            end else if (RST) begin
                chk("rdy_ed0", longint'(RDY), 0);
                if (have_last) begin
                    chk("dor_hold", longint'(DOR), longint'(last_dor));
                    chk("doi_hold", longint'(DOI), longint'(last_doi));
                end
            end
        end
    end

    initial begin
        real ang;
        for (int n = 0; n < 64; n++) begin
            ang = 2.0 * 3.14159265358979 * real'((n >> 3) * (n & 7)) / 64.0;
            wr_rom[n] = NW'(rnd(32767.0 * $cos(ang)));
            wi_rom[n] = NW'(rnd(-32767.0 * $sin(ang)));
        end

        #2 RST = 1'b0;
        #1;
        chk("init_addr", longint'(ADDR), 0);
        chk("init_dor", longint'(DOR), 0);
        chk("init_doi", longint'(DOI), 0);
        chk("init_rdy", longint'(RDY), 0);
        repeat (2) @(negedge CLK);
        release_rst();

        // idle: data flows with w0, no RDY
        for (int i = 0; i < 4; i++) step(1, 0, 500 - i * 100, -300 + i * 50);

        // full frame; indices 0, 20, 36 hand-checked
        for (int i = 0; i < 64; i++) begin
            if (i == 0)       step(1, 1, 1000, 0, 1, H0, 0);
            else if (i == 20) step(1, 0, 1000, 0, 1, 707, H20I);
            else if (i == 36) step(1, 0, 0, 1000, 1, H0, 0);
            else              step(1, 0, 1000, 0);
        end

        // back-to-back frame: index 0 again with marker
        step(1, 0, 1000, 0, 1, H0, 0);

        // ED pattern 1,0,0,1 with junk data on stalled cycles
        for (int i = 1; i <= 12; i++) begin
            step(1, 0, 37 * i - 200, 200 - 13 * i);
            if (i % 4 == 1) begin
                step(0, 0, 12345, -12345);
                step(0, 0, -999, 777);
            end
        end

        // run to index 40, then restart mid-frame
        for (int i = 13; i <= 40; i++) step(1, 0, 90 * i - 2000, 1500 - 70 * i);
        step(1, 1, -1200, 800);
        for (int i = 1; i < 6; i++) step(1, 0, 300 * i, -250 * i);
        step(0, 0, 1, 1);

        // reset mid-run with ED high
        for (int i = 6; i < 9; i++) step(1, 0, 300 * i, -250 * i);
        do_reset(1);
        step(1, 0, 4000, 4000);
        step(1, 0, 4000, 4000);
        release_rst();
        for (int i = 0; i < 6; i++) step(1, 0, -800 + 300 * i, 600 - 100 * i);

        // drain without issuing new expectations
        repeat (3) begin
            @(negedge CLK);
            ED = 1'b1;
            START = 1'b0;
            ed_issue++;
        end
        @(negedge CLK);
        ED = 1'b0;
        repeat (2) @(negedge CLK);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d outputs pending, expected 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
